// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_if.sv
// Issue/result bus between the arithmetic issue logic and the divider.
interface div_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_op;
    logic             start;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dz;
    logic             busy;
    logic             vld;

    modport master (
        output a, b, signed_op, start,
        input  quo, rem, dz, busy, vld
    );

    modport slave (
        input  a, b, signed_op, start,
        output quo, rem, dz, busy, vld
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shift_c;

    // Extra MSB keeps the carry out of the shift for the compare.
    assign shift_c = {rem_i, bit_i};
    assign qbit_o  = (shift_c >= {1'b0, dvs_i});
    assign rem_o   = qbit_o ? (shift_c[WIDTH-1:0] - dvs_i) : shift_c[WIDTH-1:0];

endmodule

// File: rtl/div.sv
// Sequential signed/unsigned restoring divider, one quotient bit per clock,
// start/vld handshake matching the shift-add multiplier.
module div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  div_io
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] a_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             dz_pend_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_q;
    logic             vld_q;
    logic             busy_q;

    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;
    logic [WIDTH-1:0] r_d;
    logic             qbit_d;

    assign a_neg_c = div_io.signed_op & div_io.a[WIDTH-1];
    assign b_neg_c = div_io.signed_op & div_io.b[WIDTH-1];
    assign mag_a_c = a_neg_c ? -div_io.a : div_io.a;
    assign mag_b_c = b_neg_c ? -div_io.b : div_io.b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (r_q),
        .bit_i  (dvd_q[WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (r_d),
        .qbit_o (qbit_d)
    );

    // Counter runs WIDTH-1 down to -1; the extra edge at -1 applies sign
    // correction and publishes the result, giving WIDTH+1 cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            r_q       <= '0;
            a_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_pend_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    vld_q <= 1'b0;
                    if (div_io.start) begin
                        dvd_q     <= mag_a_c;
                        dvs_q     <= mag_b_c;
                        r_q       <= '0;
                        a_q       <= div_io.a;
                        neg_quo_q <= a_neg_c ^ b_neg_c;
                        neg_rem_q <= a_neg_c;
                        dz_pend_q <= (div_io.b == '0);
                        cnt_q     <= CW'(WIDTH - 1);
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                CALC: begin
                    if (cnt_q[CW-1]) begin
                        if (dz_pend_q) begin
                            quo_q <= '1;
                            rem_q <= a_q;
                        end else begin
                            quo_q <= neg_quo_q ? -dvd_q : dvd_q;
                            rem_q <= neg_rem_q ? -r_q : r_q;
                        end
                        dz_q    <= dz_pend_q;
                        vld_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        dvd_q <= {dvd_q[WIDTH-2:0], qbit_d};
                        r_q   <= r_d;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign div_io.quo  = quo_q;
    assign div_io.rem  = rem_q;
    assign div_io.dz   = dz_q;
    assign div_io.vld  = vld_q;
    assign div_io.busy = busy_q;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the sequential divider.
module tb_div;
    import div_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_if #(.WIDTH(W)) dif ();

    div #(.WIDTH(W)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .div_io (dif)
    );

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents operands with start for one edge; returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        dif.a         = a;
        dif.b         = b;
        dif.signed_op = s;
        dif.start     = 1'b1;
        @(posedge clk);
        #1 dif.start  = 1'b0;
    endtask

    // Counts edges until vld is seen, bounded; an expired bound yields a bad latency.
    task automatic wait_vld(output int lat);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (dif.vld === 1'b1) break;
        end
    endtask

    initial begin
        int  lat;
        int  pre;
        logic seen;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
        vecs[2] = '{32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2,          1'b0};
        vecs[3] = '{32'hFFFF_FFFF,  32'd16,         1'b0, 32'h0FFF_FFFF,  32'd15,         1'b0};
        vecs[4] = '{32'hFFFF_FFFF,  32'd16,         1'b1, 32'd0,          32'hFFFF_FFFF,  1'b0};
        vecs[5] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1};
        vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};

        rst           = 1'b1;
        dif.start     = 1'b0;
        dif.a         = '0;
        dif.b         = '0;
        dif.signed_op = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_quo",  dif.quo, '0);
        check("rst_rem",  dif.rem, '0);
        check("rst_dz",   W'(dif.dz), '0);
        check("rst_vld",  W'(dif.vld), '0);
        check("rst_busy", W'(dif.busy), '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].s);
            check($sformatf("v%0d_busy_on", i), W'(dif.busy), W'(1));
            wait_vld(lat);
            check($sformatf("v%0d_latency", i), W'(lat), W'(LAT));
            check($sformatf("v%0d_quo", i), dif.quo, vecs[i].q);
            check($sformatf("v%0d_rem", i), dif.rem, vecs[i].r);
            check($sformatf("v%0d_dz", i), W'(dif.dz), W'(vecs[i].dz));
            check($sformatf("v%0d_busy_in_vld", i), W'(dif.busy), '0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_vld_width", i), W'(dif.vld), '0);
            check($sformatf("v%0d_quo_hold", i), dif.quo, vecs[i].q);
        end

        // start while busy must not disturb the running operation
        issue(32'd100, 32'd7, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        issue(32'd9, 32'd3, 1'b0);
        pre = 5;
        wait_vld(lat);
        check("busy_start_latency", W'(pre + lat), W'(LAT));
        check("busy_start_quo", dif.quo, 32'd14);
        check("busy_start_rem", dif.rem, 32'd2);

        // back-to-back: start accepted in the vld cycle
        issue(32'd9, 32'd3, 1'b0);
        check("b2b_vld_low",  W'(dif.vld), '0);
        check("b2b_busy",     W'(dif.busy), W'(1));
        check("b2b_quo_held", dif.quo, 32'd14);
        wait_vld(lat);
        check("b2b_latency", W'(lat), W'(LAT));
        check("b2b_quo", dif.quo, 32'd3);
        check("b2b_rem", dif.rem, 32'd0);
        @(posedge clk);
        #1;

        // reset mid-operation
        issue(32'd1000, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_quo",  dif.quo, '0);
        check("midrst_rem",  dif.rem, '0);
        check("midrst_dz",   W'(dif.dz), '0);
        check("midrst_busy", W'(dif.busy), '0);
        check("midrst_vld",  W'(dif.vld), '0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= dif.vld;
        end
        check("midrst_no_vld", W'(seen), '0);
        issue(32'd9, 32'd3, 1'b0);
        wait_vld(lat);
        check("post_rst_latency", W'(lat), W'(LAT));
        check("post_rst_quo", dif.quo, 32'd3);
        check("post_rst_rem", dif.rem, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
